// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_BITS = 2;

  function automatic int cntWidth(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One partial-product row: s = A + M*q0 + (M<<1)*q1, rippled through 2-bit multiply/add cells.
module mult_pp_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_q0,
  input  logic             i_q1,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH+1:0] o_s
);

  logic [WIDTH:0]        w_mx;
  logic [WIDTH:0]        w_m1;
  logic [WIDTH:0]        w_ax;
  logic [WIDTH+1:0][1:0] w_cy;
  logic [WIDTH:0][2:0]   w_tot;

  assign w_mx     = {1'b0, i_m};
  assign w_m1     = {i_m, 1'b0};
  assign w_ax     = {1'b0, i_a};
  assign w_cy[0]  = 2'b00;

  // Each cell sums up to three product/accumulator bits plus a carry of 0..2.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    assign w_tot[i]  = 3'(w_mx[i] & i_q0) + 3'(w_m1[i] & i_q1) + 3'(w_ax[i]) + {1'b0, w_cy[i]};
    assign o_s[i]    = w_tot[i][0];
    assign w_cy[i+1] = w_tot[i][2:1];
  end

  // Only M[W-1]*q1 and a carry reach the top cell, so its carry-out is 0 or 1.
  assign o_s[WIDTH+1] = |w_cy[WIDTH+1];

endmodule

// File: rtl/mult_seq_radix4.sv
// Sequential unsigned multiplier retiring two multiplier bits per clock.
// Optional zero-operand shortcut enabled by defining MULT_ZERO_BYPASS_EN.
module mult_seq_radix4
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / STEP_BITS;
  localparam int CNT_W = cntWidth(STEPS);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("mult_seq_radix4: WIDTH must be even and >= 4");
  end

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_m;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH+1:0]     w_s;
  logic                 w_zero;

`ifdef MULT_ZERO_BYPASS_EN
  assign w_zero = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero = 1'b0;
`endif

  mult_pp_row #(.WIDTH(WIDTH)) u_row (
    .i_m  (r_m),
    .i_q0 (r_q[0]),
    .i_q1 (r_q[1]),
    .i_a  (r_a),
    .o_s  (w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_m   <= multiplicand;
            r_q   <= multiplier;
            r_a   <= '0;
            r_cnt <= CNT_W'(STEPS - 1);
            if (w_zero) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_product <= '0;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= w_s[WIDTH+1:STEP_BITS];
          r_q   <= {w_s[STEP_BITS-1:0], r_q[WIDTH-1:STEP_BITS]};
          r_cnt <= r_cnt - 1'b1;
          // Final step: the shifted {s, Q} is the complete product.
          if (r_cnt == '0) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_product <= {w_s, r_q[WIDTH-1:STEP_BITS]};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mult_seq_radix4.sv
// Randomized and directed bench for mult_seq_radix4 (WIDTH=8) against an arithmetic reference.
module tb_mult_seq_radix4;

  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          checksPassed = 0;
  int          checksTotal = 0;
  logic [15:0] lastProduct = '0;

  mult_seq_radix4 #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] refProduct(input logic [7:0] m, input logic [7:0] q);
    return 16'(m) * 16'(q);
  endfunction

  function automatic int refLatency(input logic [7:0] m, input logic [7:0] q);
`ifdef MULT_ZERO_BYPASS_EN
    if (m == 8'd0 || q == 8'd0) return 0;
`endif
    return STEPS;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Called at a negedge with the DUT idle or in its done cycle; returns at the negedge of the done cycle.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q, input string tag, input bit midStart);
    int busyCycles;
    int waited;
    bit heldOk;
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom_range(0, 255));
    multiplier   = 8'($urandom_range(0, 255));
    busyCycles   = 0;
    waited       = 0;
    heldOk       = 1'b1;
    while (done !== 1'b1 && waited < 20) begin
      if (busy === 1'b1) busyCycles++;
      if (product !== lastProduct) heldOk = 1'b0;
      @(negedge clk);
      waited++;
      start = midStart && (waited == 1);
      if (start) begin
        multiplicand = m ^ 8'h5A;
        multiplier   = q ^ 8'hA5;
      end
    end
    start = 1'b0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(waited), 32'(refLatency(m, q)));
    checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(refLatency(m, q)));
    checkOutput({tag, "_product"}, 32'(product), 32'(refProduct(m, q)));
    checkOutput({tag, "_heldBefore"}, 32'(heldOk), 32'd1);
    lastProduct = refProduct(m, q);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_idleDone"}, 32'(done), 32'd0);
    checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idleProduct"}, 32'(product), 32'(lastProduct));
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] q;

    #12;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetProduct", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd13, 8'd11, "m13q11", 1'b0);
    checkIdle("m13q11");
    applyStimulus(8'hFF, 8'hFF, "maxOps", 1'b0);
    checkIdle("maxOps");
    applyStimulus(8'd100, 8'd37, "midStart", 1'b1);
    checkIdle("midStart");
    applyStimulus(8'd9, 8'd9, "preBackToBack", 1'b0);
    applyStimulus(8'd3, 8'd5, "backToBack", 1'b0);
    checkIdle("backToBack");

    // Asynchronous reset in the middle of a run.
    start        = 1'b1;
    multiplicand = 8'd77;
    multiplier   = 8'd99;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetDone", 32'(done), 32'd0);
    checkOutput("midResetProduct", 32'(product), 32'd0);
    lastProduct = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'd7, 8'd6, "afterReset", 1'b0);
    checkIdle("afterReset");

    applyStimulus(8'd0, 8'd200, "zeroM", 1'b0);
    checkIdle("zeroM");

    for (int i = 0; i < 16; i++) begin
      m = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      q = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      applyStimulus(m, q, $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) checkIdle($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
